// File: rtl/sysu_dec_arbiter.sv
// Round-robin arbiter driving a shared 3-to-8 active-low chip-select decoder.
// Adds one dead cycle between owners and a watchdog that forces release after MAX_HOLD cycles.
module sysu_dec_arbiter #(
   parameter int N_REQ    = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [2:0]       sel_a,
   output logic             sel_en,
   output logic [7:0]       gnt_n,
   output logic             busy,
   output logic             timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [2:0] PTR_RST  = 3'(N_REQ - 1);
   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

   state_t     state, state_nx;
   logic [2:0] ptr, ptr_nx;
   logic [2:0] sel_a_nx;
   logic       sel_en_nx;
   logic       timeout_nx;
   logic [7:0] hold_cnt, hold_nx;
   logic [7:0] blocked, blocked_nx;
   logic [7:0] req_ext;
   logic [7:0] eff;
   logic [2:0] win;
   logic       win_vld;
   int         idx;

   // Widening to the decoder's 8 outputs keeps non-existent requesters permanently at 0.
   assign req_ext = 8'(req);
   assign eff     = req_ext & ~blocked;

   // Circular search starting just after the last owner; the first hit wins.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (!win_vld && eff[idx]) begin
            win     = 3'(idx);
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
      state_nx   = state;
      sel_a_nx   = sel_a;
      sel_en_nx  = 1'b0;
      ptr_nx     = ptr;
      hold_nx    = hold_cnt;
      timeout_nx = 1'b0;
      blocked_nx = blocked & req_ext;

      case (state)
         IDLE, GAP: begin
            if (win_vld) begin
               state_nx  = GRANT;
               sel_a_nx  = win;
               sel_en_nx = 1'b1;
               ptr_nx    = win;
               hold_nx   = '0;
            end else begin
               state_nx = IDLE;
            end
         end
         GRANT: begin
            hold_nx = hold_cnt + 8'd1;
            // A release wins over a coincident hold-limit expiry: no timeout, no blocking.
            if (!req_ext[sel_a]) begin
               state_nx = GAP;
            end else if (hold_cnt == HOLD_LIM) begin
               state_nx            = GAP;
               timeout_nx          = 1'b1;
               blocked_nx[sel_a]   = 1'b1;
            end else begin
               sel_en_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel_a    <= '0;
         sel_en   <= 1'b0;
         ptr      <= PTR_RST;
         hold_cnt <= '0;
         blocked  <= '0;
         timeout  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state    <= state_nx;
         sel_a    <= sel_a_nx;
         sel_en   <= sel_en_nx;
         ptr      <= ptr_nx;
         hold_cnt <= hold_nx;
         blocked  <= blocked_nx;
         timeout  <= timeout_nx;
      end
   end

   assign busy = (state == GRANT);

   // Mirrors the external decoder exactly, built only from registered sel_a/sel_en.
   always_comb begin
      gnt_n = 8'hFF;
      if (sel_en && (int'(sel_a) < N_REQ)) gnt_n[sel_a] = 1'b0;
   end

endmodule

// File: tb/tb_sysu_dec_arbiter.sv
// Self-checking bench for sysu_dec_arbiter: per-cycle expectations pushed to a
// scoreboard queue as stimulus is driven, popped and compared after each edge.
module tb_sysu_dec_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = 8'h00;
   logic [2:0] sel_a;
   logic       sel_en;
   logic [7:0] gnt_n;
   logic       busy;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [7:0] gnt_n;
      logic       to;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] exp_sel = 3'd0;

   sysu_dec_arbiter #(.N_REQ(8), .MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .sel_a   (sel_a),
      .sel_en  (sel_en),
      .gnt_n   (gnt_n),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Drive req for one edge (called at a falling edge), compare after the edge, return at the next falling edge.
   task automatic cyc(input string tag, input logic [7:0] r, input logic [7:0] g, input logic to);
      exp_t e;
      req   = r;
      e.tag = tag;
      e.gnt_n = g;
      e.to  = to;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.gnt_n != 8'hFF) begin
         for (int i = 0; i < 8; i++) if (!e.gnt_n[i]) exp_sel = 3'(i);
      end
      check({e.tag, " gnt_n"},   32'(gnt_n),   32'(e.gnt_n));
      check({e.tag, " sel_en"},  32'(sel_en),  32'(e.gnt_n != 8'hFF));
      check({e.tag, " busy"},    32'(busy),    32'(e.gnt_n != 8'hFF));
      check({e.tag, " timeout"}, 32'(timeout), 32'(e.to));
      check({e.tag, " sel_a"},   32'(sel_a),   32'(exp_sel));
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag, input logic [7:0] r);
      rst_n = 1'b0;
      req   = r;
      #2;
      exp_sel = 3'd0;
      check({tag, " rst gnt_n"},   32'(gnt_n),   32'hFF);
      check({tag, " rst sel_en"},  32'(sel_en),  32'd0);
      check({tag, " rst busy"},    32'(busy),    32'd0);
      check({tag, " rst timeout"}, 32'(timeout), 32'd0);
      check({tag, " rst sel_a"},   32'(sel_a),   32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      @(negedge clk);

      // Reset with every request high, then req[0] wins first.
      do_reset("t1", 8'hFF);
      cyc("t1 first", 8'hFF, 8'hFE, 1'b0);
      cyc("t1 rel",   8'h00, 8'hFF, 1'b0);
      cyc("t1 idle",  8'h00, 8'hFF, 1'b0);

      // Round-robin 0,2,0,2 with one dead cycle between owners.
      do_reset("t2", 8'h00);
      for (int n = 0; n < 2; n++) begin
         cyc("t2 g0",    8'h05, 8'hFE, 1'b0);
         cyc("t2 g0",    8'h05, 8'hFE, 1'b0);
         cyc("t2 g0",    8'h05, 8'hFE, 1'b0);
         cyc("t2 gap0",  8'h04, 8'hFF, 1'b0);
         cyc("t2 g2",    8'h05, 8'hFB, 1'b0);
         cyc("t2 g2",    8'h05, 8'hFB, 1'b0);
         cyc("t2 g2",    8'h05, 8'hFB, 1'b0);
         cyc("t2 gap2",  8'h01, 8'hFF, 1'b0);
      end
      cyc("t2 idle", 8'h00, 8'hFF, 1'b0);

      // Wrap-around from ptr=6: 7 before 1.
      do_reset("t3", 8'h00);
      cyc("t3 g6",   8'h40, 8'hBF, 1'b0);
      cyc("t3 gap",  8'h00, 8'hFF, 1'b0);
      cyc("t3 g7",   8'h82, 8'h7F, 1'b0);
      cyc("t3 g7",   8'h82, 8'h7F, 1'b0);
      cyc("t3 gap7", 8'h02, 8'hFF, 1'b0);
      cyc("t3 g1",   8'h02, 8'hFD, 1'b0);
      cyc("t3 rel",  8'h00, 8'hFF, 1'b0);
      cyc("t3 idle", 8'h00, 8'hFF, 1'b0);

      // Watchdog: owner 3 held for MAX_HOLD=4 cycles, then blocked until it drops req.
      do_reset("t4", 8'h00);
      for (int n = 0; n < 4; n++) cyc("t4 g3", 8'h28, 8'hF7, 1'b0);
      cyc("t4 tmo",     8'h28, 8'hFF, 1'b1);
      cyc("t4 g5",      8'h28, 8'hDF, 1'b0);
      cyc("t4 g5",      8'h28, 8'hDF, 1'b0);
      cyc("t4 rel5",    8'h08, 8'hFF, 1'b0);
      cyc("t4 blk",     8'h08, 8'hFF, 1'b0);
      cyc("t4 blk",     8'h08, 8'hFF, 1'b0);
      cyc("t4 drop3",   8'h00, 8'hFF, 1'b0);
      cyc("t4 regrant", 8'h08, 8'hF7, 1'b0);
      cyc("t4 rel",     8'h00, 8'hFF, 1'b0);
      cyc("t4 idle",    8'h00, 8'hFF, 1'b0);

      // Release lands on the hold-limit edge: no timeout, no blocking.
      do_reset("t5", 8'h00);
      for (int n = 0; n < 4; n++) cyc("t5 g2", 8'h04, 8'hFB, 1'b0);
      cyc("t5 rel",     8'h00, 8'hFF, 1'b0);
      cyc("t5 regrant", 8'h04, 8'hFB, 1'b0);
      cyc("t5 rel2",    8'h00, 8'hFF, 1'b0);
      cyc("t5 idle",    8'h00, 8'hFF, 1'b0);

      // Asynchronous reset between edges while owner 4 holds the grant.
      do_reset("t6", 8'h00);
      cyc("t6 g4", 8'h10, 8'hEF, 1'b0);
      cyc("t6 g4", 8'h11, 8'hEF, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6 async gnt_n",  32'(gnt_n),  32'hFF);
      check("t6 async sel_en", 32'(sel_en), 32'd0);
      check("t6 async busy",   32'(busy),   32'd0);
      exp_sel = 3'd0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc("t6 after", 8'h11, 8'hFE, 1'b0);
      cyc("t6 rel",   8'h00, 8'hFF, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sysu_dec_arbiter.md
Name: sysu_dec_arbiter

Overview:
Round-robin arbiter that shares one 3-to-8 active-low chip-select decoder among up to 8 requesters. It drives the decoder's address lines A2..A0 and its enable (E1; E2_n/E3_n tied low externally). It also produces the equivalent registered active-low grant vector internally, so downstream logic sees exactly what the decoder outputs. It enforces a one-cycle dead time between owners and a watchdog hold limit.

Parameters:
N_REQ, 8, number of requesters (2..8); unused decoder outputs are never selected.
MAX_HOLD, 16, maximum consecutive grant cycles per owner (2..255) before forced release.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req  input  N_REQ  request bits, active-high, level; held high for the whole ownership.
sel_a  output  3  decoder address {A2,A1,A0}, registered.
sel_en  output  1  decoder enable E1, registered; high only in GRANT.
gnt_n  output  8  active-low one-hot grant; all ones when sel_en=0, else bit sel_a low.
busy  output  1  high in GRANT.
timeout  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (async, rst_n=0):
  - sel_a=0, sel_en=0, gnt_n=8'hFF, busy=0, timeout=0.
  - State IDLE, last-owner pointer ptr=N_REQ-1, so req[0] has first priority.
  - hold_cnt=0, blocked mask=0.
  - Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- Effective request eff = req & ~blocked.
- Winner: the first set bit of eff searched circularly from ptr+1 through ptr, wrapping at N_REQ-1 -> 0.
- States:
  - IDLE:
    - If eff≠0: go to GRANT, sel_a=winner, sel_en=1, ptr=winner, hold_cnt=0.
    - Latency: req sampled at edge t, grant visible after edge t.
  - GRANT:
    - Each cycle, hold_cnt increments.
    - If req[sel_a]=0 at an edge: go to GAP, sel_en=0.
    - Else if hold_cnt=MAX_HOLD-1: go to GAP, sel_en=0, timeout=1 for one cycle, blocked[sel_a]=1.
    - Otherwise stay in GRANT.
    - Requests from other sources never pre-empt.
  - GAP:
    - Exactly one cycle with sel_en=0 (dead time).
    - On the next edge, behaves as IDLE: grant the winner if eff≠0, else go to IDLE.
- blocked[i] clears on any edge where req[i]=0. A timed-out owner therefore cannot regain the grant until it drops and re-raises req.
- gnt_n is derived combinationally from the registered sel_a/sel_en and is glitch-free relative to them: 3→8 decode, active-low, 8'hFF when disabled.
- sel_a holds its last value while sel_en=0.
- Simultaneous events:
  - Release and timeout on the same edge count as a release; timeout stays 0 and nothing is blocked.
  - A new request arriving in the same cycle as a release is arbitrated in GAP.
- req bits at index ≥N_REQ do not exist; gnt_n bits ≥N_REQ are always 1.
- Ownership is at least 1 cycle and at most MAX_HOLD cycles.
- Minimum owner-to-owner turnaround is 1 idle cycle.

Test Plan:
1. Reset: with rst_n=0 and req=8'hFF, check gnt_n=8'hFF, sel_en=0, busy=0. Release rst_n; after the next edge, check sel_a=0 and gnt_n=8'hFE.
2. Round-robin: hold req=8'b0000_0101. Each owner drops req for 1 cycle after 3 grant cycles, then re-raises it. Grant order must be 0,2,0,2, with exactly one cycle of gnt_n=8'hFF between owners.
3. Wrap-around: ptr=6, req=8'b1000_0010. Expect grant 7 first, then 1; sel_a shows 7 then 1.
4. Watchdog: MAX_HOLD=4, req[3] held high, req[5] high. gnt_n=8'hF7 for 4 cycles, then timeout pulses once. Next comes one gap cycle, then gnt_n=8'hDF. After owner 5 releases, 3 is not re-granted until req[3] has been low for 1 cycle.
5. Release coincident with the hold limit: owner drops req exactly at the MAX_HOLD-1 edge. Expect timeout=0 and no blocking; the owner is re-grantable on its next request.
6. Asynchronous reset mid-GRANT, asserted between clock edges: gnt_n becomes 8'hFF immediately. After reset, ptr is back to N_REQ-1, so req=8'b0001_0001 grants 0 first.
